// File: rtl/dragon_head_ctrl.sv
// dragon_head_ctrl
// Moves the dragon's head one grid cell per movement tick, wrapping at the
// grid edges. Each step is classified MOVE / HEAL / HIT from the collision
// events seen since the previous step. The result goes to the body shift
// register as one {orientation, x, y} word plus a state code, marked by a
// single-cycle strobe.
//
// Optional feature macro: DRAGON_NO_REVERSE_EN
//   defined   - a direction request opposite the current orientation is dropped
//   undefined - every request is accepted (the head may reverse onto its neck)
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high reset
//   run        in   game running; ticks are ignored while low
//   move_tick  in   one-cycle step request
//   dir_in     in   [1:0] requested direction: 00 up, 01 right, 10 down, 11 left
//   dir_valid  in   dir_in is valid this cycle
//   heal_evt   in   head touched a heart (pulse)
//   hit_evt    in   head touched a hazard (pulse)
//   orien_pos  out  [11:0] {orientation[1:0], x[4:0], y[4:0]}
//   states     out  [1:0] 00 MOVE, 01 HEAL, 10 HIT, 11 IDLE
//   seg_valid  out  one-cycle strobe qualifying orien_pos / states
//   tail_ptr   out  [2:0] body length minus one
//   dead       out  game over, sticky until reset
module dragon_head_ctrl #(
    parameter int GRID_W  = 20,
    parameter int GRID_H  = 15,
    parameter int START_X = 10,
    parameter int START_Y = 7,
    parameter int MAX_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        move_tick,
    input  logic [1:0]  dir_in,
    input  logic        dir_valid,
    input  logic        heal_evt,
    input  logic        hit_evt,
    output logic [11:0] orien_pos,
    output logic [1:0]  states,
    output logic        seg_valid,
    output logic [2:0]  tail_ptr,
    output logic        dead
);

    typedef enum logic [1:0] {S_WAIT, S_STEP, S_EMIT} state_t;

    localparam logic [1:0]  ST_MOVE = 2'b00;
    localparam logic [1:0]  ST_HEAL = 2'b01;
    localparam logic [1:0]  ST_HIT  = 2'b10;
    localparam logic [1:0]  ST_IDLE = 2'b11;
    localparam logic [11:0] POS_RST = {2'b01, 5'(START_X), 5'(START_Y)};

    state_t      state_q, state_d;
    logic [1:0]  pend_dir_q, pend_dir_d;
    logic        heal_f_q, heal_f_d;
    logic        hit_f_q, hit_f_d;
    logic [11:0] orien_pos_q, orien_pos_d;
    logic [1:0]  states_q, states_d;
    logic        seg_valid_q, seg_valid_d;
    logic [2:0]  tail_ptr_q, tail_ptr_d;
    logic        dead_q, dead_d;

    logic [4:0]  cur_x, cur_y, nxt_x, nxt_y;

    assign cur_x = orien_pos_q[9:5];
    assign cur_y = orien_pos_q[4:0];

    // Next head cell in the pending direction, wrapping at the grid edges.
    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        case (pend_dir_q)
            2'b00:   nxt_y = (cur_y == 5'd0) ? 5'(GRID_H - 1) : cur_y - 5'd1;
            2'b01:   nxt_x = (cur_x == 5'(GRID_W - 1)) ? 5'd0 : cur_x + 5'd1;
            2'b10:   nxt_y = (cur_y == 5'(GRID_H - 1)) ? 5'd0 : cur_y + 5'd1;
            default: nxt_x = (cur_x == 5'd0) ? 5'(GRID_W - 1) : cur_x - 5'd1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pend_dir_d  = pend_dir_q;
        heal_f_d    = heal_f_q;
        hit_f_d     = hit_f_q;
        orien_pos_d = orien_pos_q;
        states_d    = ST_IDLE;
        seg_valid_d = 1'b0;
        tail_ptr_d  = tail_ptr_q;
        dead_d      = dead_q;

        // Direction capture runs in every state; the last request before STEP wins.
        if (dir_valid) begin
`ifdef DRAGON_NO_REVERSE_EN
            if ((dir_in ^ orien_pos_q[11:10]) != 2'b10)
                pend_dir_d = dir_in;
`else
            pend_dir_d = dir_in;
`endif
        end

        case (state_q)
            S_WAIT: begin
                if (move_tick && run && !dead_q)
                    state_d = S_STEP;
            end
            S_STEP: begin
                state_d = S_EMIT;
                // The outputs registered here are what the EMIT cycle presents.
                if (hit_f_q && tail_ptr_q == 3'd0) begin
                    dead_d = 1'b1;
                end else begin
                    orien_pos_d = {pend_dir_q, nxt_x, nxt_y};
                    seg_valid_d = 1'b1;
                    if (hit_f_q) begin
                        states_d   = ST_HIT;
                        tail_ptr_d = tail_ptr_q - 3'd1;
                    end else if (heal_f_q && int'(tail_ptr_q) < MAX_LEN - 1) begin
                        states_d   = ST_HEAL;
                        tail_ptr_d = tail_ptr_q + 3'd1;
                    end else begin
                        states_d   = ST_MOVE;
                    end
                end
            end
            S_EMIT: begin
                state_d  = S_WAIT;
                heal_f_d = 1'b0;
                hit_f_d  = 1'b0;
            end
            default: state_d = S_WAIT;
        endcase

        // Set beats clear so a pulse landing in EMIT carries to the next step.
        if (heal_evt) heal_f_d = 1'b1;
        if (hit_evt)  hit_f_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT;
            pend_dir_q  <= 2'b01;
            heal_f_q    <= 1'b0;
            hit_f_q     <= 1'b0;
            orien_pos_q <= POS_RST;
            states_q    <= ST_IDLE;
            seg_valid_q <= 1'b0;
            tail_ptr_q  <= 3'd0;
            dead_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_dir_q  <= pend_dir_d;
            heal_f_q    <= heal_f_d;
            hit_f_q     <= hit_f_d;
            orien_pos_q <= orien_pos_d;
            states_q    <= states_d;
            seg_valid_q <= seg_valid_d;
            tail_ptr_q  <= tail_ptr_d;
            dead_q      <= dead_d;
        end
    end

    assign orien_pos = orien_pos_q;
    assign states    = states_q;
    assign seg_valid = seg_valid_q;
    assign tail_ptr  = tail_ptr_q;
    assign dead      = dead_q;

endmodule

// File: tb/tb_dragon_head_ctrl.sv
// Self-checking bench for dragon_head_ctrl: directed steps plus a random walk,
// each compared against a grid-level model of the head (position, length,
// liveness) kept with plain integer arithmetic.
module tb_dragon_head_ctrl;

    localparam int W = 20, H = 15, SX = 10, SY = 7, ML = 8;

    logic        clk = 1'b0;
    logic        reset, run, move_tick, dir_valid, heal_evt, hit_evt;
    logic [1:0]  dir_in;
    logic [11:0] orien_pos;
    logic [1:0]  states;
    logic        seg_valid, dead;
    logic [2:0]  tail_ptr;

    dragon_head_ctrl #(.GRID_W(W), .GRID_H(H), .START_X(SX), .START_Y(SY), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset), .run(run), .move_tick(move_tick),
        .dir_in(dir_in), .dir_valid(dir_valid), .heal_evt(heal_evt), .hit_evt(hit_evt),
        .orien_pos(orien_pos), .states(states), .seg_valid(seg_valid),
        .tail_ptr(tail_ptr), .dead(dead)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    // Model: head cell, orientation, body length (1..ML), liveness, pending state.
    int mx, my, mori, mpend, mlen;
    bit mdead, mheal, mhit;

`ifdef DRAGON_NO_REVERSE_EN
    localparam bit NOREV = 1'b1;
`else
    localparam bit NOREV = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mx = SX; my = SY; mori = 1; mpend = 1; mlen = 1;
        mdead = 0; mheal = 0; mhit = 0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_sv"}, 32'(seg_valid), 32'd0);
        chk({tag, "_st"}, 32'(states), 32'd3);
        chk({tag, "_pos"}, 32'(orien_pos), 32'((mori << 10) | (mx << 5) | my));
        chk({tag, "_tail"}, 32'(tail_ptr), 32'(mlen - 1));
        chk({tag, "_dead"}, 32'(dead), 32'(mdead));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; run = 1'b1; move_tick = 1'b0; dir_valid = 1'b0;
        dir_in = 2'b00; heal_evt = 1'b0; hit_evt = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check_idle("reset");
    endtask

    // One request cycle (direction / events), then a tick, then the strobe check.
    task automatic do_step(input bit dv, input logic [1:0] d, input bit he, input bit hi);
        int exp_sv, exp_st;
        @(negedge clk);
        dir_valid = dv; dir_in = d; heal_evt = he; hit_evt = hi;
        if (dv && !(NOREV && ((int'(d) ^ mori) == 2))) mpend = int'(d);
        if (he) mheal = 1;
        if (hi) mhit = 1;
        @(negedge clk);
        dir_valid = 1'b0; heal_evt = 1'b0; hit_evt = 1'b0; move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
        chk("early_sv", 32'(seg_valid), 32'd0);
        @(negedge clk);
        exp_sv = 0; exp_st = 3;
        if (run && !mdead) begin
            if (mhit && mlen == 1) begin
                mdead = 1;
            end else begin
                mori = mpend;
                case (mori)
                    0: my = (my + H - 1) % H;
                    1: mx = (mx + 1) % W;
                    2: my = (my + 1) % H;
                    default: mx = (mx + W - 1) % W;
                endcase
                exp_sv = 1;
                if (mhit) begin mlen--; exp_st = 2; end
                else if (mheal && mlen < ML) begin mlen++; exp_st = 1; end
                else exp_st = 0;
            end
            mheal = 0; mhit = 0;
        end
        chk("seg_valid", 32'(seg_valid), 32'(exp_sv));
        chk("states", 32'(states), 32'(exp_st));
        chk("orien_pos", 32'(orien_pos), 32'((mori << 10) | (mx << 5) | my));
        chk("tail_ptr", 32'(tail_ptr), 32'(mlen - 1));
        chk("dead", 32'(dead), 32'(mdead));
        @(negedge clk);
        check_idle("after");
    endtask

    initial begin
        reset = 1'b1; run = 1'b1; move_tick = 1'b0; dir_valid = 1'b0;
        dir_in = 2'b00; heal_evt = 1'b0; hit_evt = 1'b0;
        model_reset();
        do_reset();

        // Plain step: expect {01, 11, 7}, MOVE.
        do_step(0, 2'b00, 0, 0);
        chk("first_pos", 32'(orien_pos), 32'({2'b01, 5'd11, 5'd7}));

        // Up to y=0 and wrap to 14.
        for (int i = 0; i < 8; i++) do_step(1, 2'b00, 0, 0);
        chk("ywrap", 32'(orien_pos), 32'({2'b00, 5'd11, 5'd14}));

        // Right to x=19 and wrap to 0.
        for (int i = 0; i < 9; i++) do_step(1, 2'b01, 0, 0);
        chk("xwrap", 32'(orien_pos), 32'({2'b01, 5'd0, 5'd14}));

        // Grow to full length; the 8th heal is a MOVE.
        for (int i = 0; i < 8; i++) do_step(0, 2'b00, 1, 0);
        chk("full_len", 32'(tail_ptr), 32'd7);

        // Shrink to tail_ptr 3, then heal+hit together is a HIT.
        for (int i = 0; i < 4; i++) do_step(0, 2'b00, 0, 1);
        do_step(0, 2'b00, 1, 1);
        chk("heal_hit", 32'(tail_ptr), 32'd2);

        // Heading right, request left.
        do_step(1, 2'b01, 0, 0);
        do_step(1, 2'b11, 0, 0);

        // run low: tick ignored; direction and events still captured.
        run = 1'b0;
        do_step(1, 2'b10, 1, 0);
        run = 1'b1;
        do_step(0, 2'b00, 0, 0);

        // Random walk; may die, after which ticks must be ignored.
        for (int i = 0; i < 40; i++)
            do_step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);

        // Hit at length 1 kills, later ticks are ignored.
        do_reset();
        do_step(0, 2'b00, 0, 1);
        chk("killed", 32'(dead), 32'd1);
        do_step(0, 2'b00, 0, 0);
        do_step(1, 2'b10, 1, 0);

        // Reset during STEP aborts the step.
        do_reset();
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0; reset = 1'b1;
        @(negedge clk);
        model_reset();
        check_idle("abort");
        reset = 1'b0;
        @(negedge clk);
        check_idle("abort2");
        do_step(0, 2'b00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
